// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time tester controller.
package reaction_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_READY = 3'b001,
        ST_GO    = 3'b010,
        ST_MISS  = 3'b011,
        ST_HIT   = 3'b110
    } state_t;

    localparam int BCD_DIGITS = 6;
    localparam logic [4*BCD_DIGITS-1:0] BCD_MAX = 24'h999999;

    // Galois mask for x^16+x^14+x^13+x^11 in right-shift form.
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// N-digit packed BCD counter with synchronous clear, increment and
// saturation at all nines.
module bcd_counter #(
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   count
);

    logic [4*DIGITS-1:0] count_inc;
    logic                carry;
    logic                saturated;

    assign saturated = (count == {DIGITS{4'h9}});

    // Ripple a single carry up from the least significant digit.
    always_comb begin
        count_inc = count;
        carry     = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count[4*i +: 4] == 4'h9) begin
                    count_inc[4*i +: 4] = 4'h0;
                end else begin
                    count_inc[4*i +: 4] = count[4*i +: 4] + 4'h1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !saturated) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: round FSM, microsecond BCD timer and last/best scores.
// Define REACTION_TIMEOUT_EN to end a GO round as MISS once the timer saturates.
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          RAND_BITS    = 10,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_btn,
    input  logic                    i_tick_us,
    input  logic                    i_bcdsel,
    output logic [2:0]              o_dst,
    output logic [4*BCD_DIGITS-1:0] o_bcd,
    output logic                    o_lit,
    output logic                    o_miss,
    output logic                    o_init
);

    localparam logic [11:0] DELAY_BASE = 12'(MIN_DELAY_MS);

    state_t                  state;
    state_t                  state_next;
    logic                    btn_q;
    logic                    press;
    logic [15:0]             lfsr;
    logic [9:0]              prescale;
    logic                    ms_tick;
    logic [11:0]             delay;
    logic [11:0]             delay_load;
    logic                    expired;
    logic                    load_delay;
    logic                    timer_clr;
    logic                    timer_inc;
    logic                    hit;
    logic [4*BCD_DIGITS-1:0] timer;
    logic [4*BCD_DIGITS-1:0] last;
    logic [4*BCD_DIGITS-1:0] best;

    assign press      = i_btn & ~btn_q;
    assign ms_tick    = i_tick_us && (prescale == 10'd999);
    assign delay_load = DELAY_BASE + 12'(lfsr[RAND_BITS-1:0]);
    assign expired    = (delay == 12'd0) || (ms_tick && (delay == 12'd1));
    assign timer_inc  = (state == ST_GO) && i_tick_us;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            btn_q <= 1'b0;
            lfsr  <= LFSR_SEED;
        end else begin
            state <= state_next;
            btn_q <= i_btn;
            lfsr  <= lfsr_next(lfsr);
        end
    end

    // A press always beats a same-cycle delay expiry in READY.
    always_comb begin
        state_next = state;
        load_delay = 1'b0;
        timer_clr  = 1'b0;
        hit        = 1'b0;
        case (state)
            ST_IDLE, ST_MISS, ST_HIT: begin
                if (press) begin
                    state_next = ST_READY;
                    load_delay = 1'b1;
                end
            end
            ST_READY: begin
                if (press) begin
                    state_next = ST_MISS;
                end else if (expired) begin
                    state_next = ST_GO;
                    timer_clr  = 1'b1;
                end
            end
            ST_GO: begin
                if (press) begin
                    state_next = ST_HIT;
                    hit        = 1'b1;
                end
`ifdef REACTION_TIMEOUT_EN
                else if (timer == BCD_MAX) begin
                    state_next = ST_MISS;
                end
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prescale <= '0;
        end else if (state_next != state) begin
            prescale <= '0;
        end else if (i_tick_us) begin
            prescale <= (prescale == 10'd999) ? 10'd0 : prescale + 10'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            delay <= '0;
        end else if (load_delay) begin
            delay <= delay_load;
        end else if ((state == ST_READY) && ms_tick && (delay != 12'd0)) begin
            delay <= delay - 12'd1;
        end
    end

    bcd_counter #(
        .DIGITS (BCD_DIGITS)
    ) u_timer (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .clr   (timer_clr),
        .inc   (timer_inc),
        .count (timer)
    );

    // Scores capture the pre-edge timer, ignoring any tick on the press cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last   <= '0;
            best   <= '0;
            o_init <= 1'b1;
        end else if (hit) begin
            last   <= timer;
            o_init <= 1'b0;
            if (o_init || (timer < best)) begin
                best <= timer;
            end
        end
    end

    assign o_dst  = state;
    assign o_lit  = (state == ST_GO);
    assign o_miss = (state == ST_MISS);
    assign o_bcd  = i_bcdsel ? best : last;

endmodule
